// File: rtl/dut_shell_pkg.sv
// Shared types, default sizes and a share-slice helper for the masked DUT shell.
package dut_shell_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DefNshare = 2;
    localparam int unsigned DefStateW = 1600;
    localparam int unsigned DefRandW  = 2;
    localparam int unsigned DefCntW   = 16;
    localparam int unsigned DefMaxCyc = 1000;

    // Widest packed share vector the helper below handles.
    localparam int unsigned MaxVecW = 8192;

    // Share k of a packed share vector (share k at [k*state_w +: state_w]), zero-extended.
    function automatic logic [MaxVecW-1:0] share_of(input logic [MaxVecW-1:0] vec,
                                                    input int unsigned k,
                                                    input int unsigned state_w);
        logic [MaxVecW-1:0] mask;
        mask = (MaxVecW'(1) << state_w) - MaxVecW'(1);
        return (vec >> (k * state_w)) & mask;
    endfunction

endpackage

// File: rtl/masked_dut_shell_if.sv
// Host-side data bus of the masked DUT shell: shared input and shared result handshakes.
interface masked_dut_shell_if
    import dut_shell_pkg::*;
#(
    parameter int unsigned NSHARE  = DefNshare,
    parameter int unsigned STATE_W = DefStateW
);
    localparam int unsigned VecW = NSHARE * STATE_W;

    logic [VecW-1:0] din;
    logic            din_vld;
    logic            din_rdy;
    logic [VecW-1:0] dout;
    logic            dout_vld;
    logic            dout_ack;

    modport master (
        output din,
        output din_vld,
        output dout_ack,
        input  din_rdy,
        input  dout,
        input  dout_vld
    );

    modport slave (
        input  din,
        input  din_vld,
        input  dout_ack,
        output din_rdy,
        output dout,
        output dout_vld
    );

endinterface

// File: rtl/dut_shell_cnt.sv
// Saturating, enable-gated cycle counter with clear, timeout compare and latency capture.
module dut_shell_cnt #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             zero,   // soft clear of counter and latency
    input  logic             clr,    // clear counter only (new operation)
    input  logic             inc,    // core-enabled cycle
    input  logic             cap,    // capture counter into lat
    output logic [CNT_W-1:0] lat,
    output logic             at_max
);

    if (64'(MAX_CYC) >= (64'd1 << CNT_W)) begin : g_max_cyc_check
        $error("MAX_CYC must be less than 2**CNT_W");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lat_q;

    // Counter: clear has priority, increment saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            lat_q <= '0;
        end else if (zero) begin
            cnt_q <= '0;
            lat_q <= '0;
        end else begin
            if (clr) begin
                cnt_q <= '0;
            end else if (inc && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cap) begin
                lat_q <= cnt_q;
            end
        end
    end

    assign lat    = lat_q;
    assign at_max = (cnt_q >= CNT_W'(MAX_CYC));

endmodule

// File: rtl/masked_dut_shell.sv
// Core-agnostic controller for masked permutation cores: captures shares, starts the core,
// gates it on randomness, captures the result, reports latency and timeout, drives trigger.
// Optional: define DUT_SHELL_DIN_CLEAR_EN to zeroise the input register after core_start.
module masked_dut_shell
    import dut_shell_pkg::*;
#(
    parameter int unsigned NSHARE  = DefNshare,
    parameter int unsigned STATE_W = DefStateW,
    parameter int unsigned RAND_W  = DefRandW,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned MAX_CYC = DefMaxCyc
) (
    input  logic                      clk,
    input  logic                      rst,
    masked_dut_shell_if.slave         host,
    input  logic [RAND_W-1:0]         r,
    input  logic                      r_vld,
    input  logic                      rst_vld,
    output logic                      trig,
    output logic                      err,
    output logic [CNT_W-1:0]          lat,
    output logic                      core_start,
    output logic                      core_en,
    output logic [NSHARE*STATE_W-1:0] core_din,
    output logic [RAND_W-1:0]         core_rand,
    input  logic [NSHARE*STATE_W-1:0] core_dout,
    input  logic                      core_done
);

    localparam int unsigned VecW = NSHARE * STATE_W;

    state_e          state_q, state_d;
    logic [VecW-1:0] din_q;
    logic [VecW-1:0] dout_q;
    logic            err_q;
    logic            trig_q;

    logic din_cap;
    logic cnt_clr;
    logic res_cap;
    logic err_set;
    logic at_max;
    logic busy;

    // Core runs only while busy and randomness is present; a soft clear abandons it at once.
    assign busy       = (state_q == StStart) || (state_q == StRun);
    assign core_en    = busy && r_vld && !rst_vld;
    assign core_start = (state_q == StStart) && r_vld && !rst_vld;
    assign core_rand  = r;
    assign core_din   = din_q;

    assign host.din_rdy  = (state_q == StIdle);
    assign host.dout_vld = (state_q == StDone);
    assign host.dout     = dout_q;

    assign trig = trig_q;
    assign err  = err_q;

    // Next-state and control strobes; soft clear overrides everything.
    always_comb begin
        state_d = state_q;
        din_cap = 1'b0;
        cnt_clr = 1'b0;
        res_cap = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (host.din_vld) begin
                    din_cap = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (r_vld) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // core_done is only meaningful on enabled cycles
                if (core_en) begin
                    if (core_done) begin
                        res_cap = 1'b1;
                        state_d = StDone;
                    end else if (at_max) begin
                        err_set = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StDone: begin
                if (host.dout_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst_vld) begin
            state_d = StIdle;
            din_cap = 1'b0;
            cnt_clr = 1'b0;
            res_cap = 1'b0;
            err_set = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Trigger registered from next state so it is glitch-free and high only in START/RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= (state_d == StStart) || (state_d == StRun);
        end
    end

    // Input share register feeding the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= '0;
        end else if (rst_vld) begin
            din_q <= '0;
        end else if (din_cap) begin
            din_q <= host.din;
`ifdef DUT_SHELL_DIN_CLEAR_EN
        end else if (core_start) begin
            // core has latched its input; do not leave shares sitting in the register
            din_q <= '0;
`endif
        end
    end

    // Result register and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            err_q  <= 1'b0;
        end else if (rst_vld) begin
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (res_cap) begin
                dout_q <= core_dout;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    dut_shell_cnt #(
        .CNT_W   (CNT_W),
        .MAX_CYC (MAX_CYC)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .zero   (rst_vld),
        .clr    (cnt_clr),
        .inc    (core_en),
        .cap    (res_cap),
        .lat    (lat),
        .at_max (at_max)
    );

endmodule

// File: tb/tb_masked_dut_shell.sv
// Scoreboard bench for masked_dut_shell with a stub core (result = input ^ 1 per share).
module tb_masked_dut_shell;
    import dut_shell_pkg::*;

    localparam int unsigned NS = 3;
    localparam int unsigned SW = 64;
    localparam int unsigned RW = 6;
    localparam int unsigned CW = 16;
    localparam int unsigned MC = 30;
    localparam int unsigned VW = NS * SW;

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        vec_t          dout;
        logic [CW-1:0] lat;
    } exp_t;

    localparam vec_t LsbMask = {64'h1, 64'h1, 64'h1};

    localparam vec_t D1 = {64'hdeadbeefcafef00d, 64'hfedcba9876543210, 64'h0123456789abcdef};
    localparam vec_t E1 = {64'hdeadbeefcafef00c, 64'hfedcba9876543211, 64'h0123456789abcdee};
    localparam vec_t D2 = {64'hffffffffffffffff, 64'h0000000000000000, 64'h1111111111111110};
    localparam vec_t E2 = {64'hfffffffffffffffe, 64'h0000000000000001, 64'h1111111111111111};
    localparam vec_t D3 = {64'h0f0f0f0f0f0f0f0f, 64'h5555555555555555, 64'haaaaaaaaaaaaaaaa};
    localparam vec_t E3 = {64'h0f0f0f0f0f0f0f0e, 64'h5555555555555554, 64'haaaaaaaaaaaaaaab};
    localparam vec_t D4 = {64'h3, 64'h2, 64'h1};
    localparam vec_t D5 = {64'h00000000ffffffff, 64'h7ffffffffffffffe, 64'h8000000000000001};
    localparam vec_t E5 = {64'h00000000fffffffe, 64'h7fffffffffffffff, 64'h8000000000000000};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] r = '0;
    logic          r_vld = 1'b0;
    logic          rst_vld = 1'b0;
    logic          trig, err, core_start, core_en, core_done;
    logic [CW-1:0] lat;
    vec_t          core_din, core_dout;
    logic [RW-1:0] core_rand;

    masked_dut_shell_if #(.NSHARE(NS), .STATE_W(SW)) hif ();

    masked_dut_shell #(
        .NSHARE  (NS),
        .STATE_W (SW),
        .RAND_W  (RW),
        .CNT_W   (CW),
        .MAX_CYC (MC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (hif),
        .r          (r),
        .r_vld      (r_vld),
        .rst_vld    (rst_vld),
        .trig       (trig),
        .err        (err),
        .lat        (lat),
        .core_start (core_start),
        .core_en    (core_en),
        .core_din   (core_din),
        .core_rand  (core_rand),
        .core_dout  (core_dout),
        .core_done  (core_done)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   trig_cnt = 0;
    exp_t exp_q[$];
    exp_t e;
    logic prev_vld = 1'b0;
    vec_t prev_dout = '0;

    // Stub core: done on its Nth enabled cycle after start; optional spurious done when disabled.
    int   stub_done_at = 0;
    bit   spur = 1'b0;
    logic stub_act;
    int   ccnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_act <= 1'b0;
            ccnt     <= 0;
        end else if (core_start) begin
            stub_act <= 1'b1;
            ccnt     <= 0;
        end else if (core_en) begin
            ccnt <= ccnt + 1;
        end
    end

    always_comb begin
        core_dout = core_din ^ LsbMask;
        core_done = stub_act && (((stub_done_at > 0) && (ccnt == stub_done_at - 1)) ||
                                 (spur && !core_en));
    end

    task automatic check(input string name, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    function automatic vec_t exp_din(input vec_t d);
`ifdef DUT_SHELL_DIN_CLEAR_EN
        return '0;
`else
        return d;
`endif
    endfunction

    // Monitor: scoreboard pop on each new result, core gating and result stability.
    always @(negedge clk) begin
        if (!rst) begin
            check1("core_en", core_en, trig && r_vld && !rst_vld);
            check("core_rand", VW'(core_rand), VW'(r));
            if (hif.dout_vld && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got result %0h expected none", hif.dout);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_dout", hif.dout, e.dout);
                    check("sb_lat", VW'(lat), VW'(e.lat));
                end
            end else if (hif.dout_vld) begin
                check("dout_stable", hif.dout, prev_dout);
            end
            if (trig) trig_cnt++;
        end
        prev_vld  = !rst && hif.dout_vld;
        prev_dout = hif.dout;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive randomness from START until a result or timeout shows up.
    task automatic finish_op(input bit alt, output int n);
        n = 0;
        while (!(hif.dout_vld || err) && n < 200) begin
            r_vld = alt ? ~n[0] : 1'b1;
            r     = RW'(n * 5 + 3);
            step();
            n++;
        end
        r_vld = 1'b0;
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL op_bound: got %0d cycles expected completion", n);
        end
    endtask

    task automatic run_op(input vec_t d, input int done_at, input bit alt, output int n);
        stub_done_at = done_at;
        trig_cnt     = 0;
        hif.din      = d;
        hif.din_vld  = 1'b1;
        step();
        hif.din_vld = 1'b0;
        finish_op(alt, n);
    endtask

    task automatic ack();
        hif.dout_ack = 1'b1;
        step();
        hif.dout_ack = 1'b0;
    endtask

    int n;
    vec_t es [NS];

    initial begin
        hif.din      = '0;
        hif.din_vld  = 1'b0;
        hif.dout_ack = 1'b0;
        es[0] = VW'(64'h0123456789abcdee);
        es[1] = VW'(64'hfedcba9876543211);
        es[2] = VW'(64'hdeadbeefcafef00c);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check1("rst_din_rdy", hif.din_rdy, 1'b1);
        check1("rst_dout_vld", hif.dout_vld, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_trig", trig, 1'b0);
        check1("rst_core_start", core_start, 1'b0);
        check("rst_lat", VW'(lat), '0);
        check("rst_dout", hif.dout, '0);
        check("rst_core_din", core_din, '0);

        // Basic run
        exp_q.push_back('{dout: E1, lat: 16'd24});
        run_op(D1, 24, 1'b0, n);
        check("basic_cycles", VW'(n), VW'(25));
        check("basic_trig_cnt", VW'(trig_cnt), VW'(25));
        check1("basic_dout_vld", hif.dout_vld, 1'b1);
        check1("basic_din_rdy", hif.din_rdy, 1'b0);
        for (int k = 0; k < NS; k++) begin
            check($sformatf("share%0d", k), VW'(share_of(MaxVecW'(hif.dout), k, SW)), es[k]);
        end
        ack();
        check1("ack_dout_vld", hif.dout_vld, 1'b0);
        check1("ack_din_rdy", hif.din_rdy, 1'b1);
        check("ack_dout_kept", hif.dout, E1);

        // Randomness stall with spurious done on disabled cycles
        spur = 1'b1;
        exp_q.push_back('{dout: E5, lat: 16'd24});
        run_op(D5, 24, 1'b1, n);
        spur = 1'b0;
        check("stall_cycles", VW'(n), VW'(49));
        check("stall_trig_cnt", VW'(trig_cnt), VW'(49));
        ack();

        // Asynchronous hard reset mid-RUN
        stub_done_at = 0;
        hif.din      = D3;
        hif.din_vld  = 1'b1;
        step();
        hif.din_vld = 1'b0;
        r_vld       = 1'b1;
        repeat (3) step();
        check1("pre_hard_trig", trig, 1'b1);
        #2 rst = 1'b1;
        #1;
        check1("hard_trig", trig, 1'b0);
        check1("hard_core_en", core_en, 1'b0);
        check1("hard_core_start", core_start, 1'b0);
        check1("hard_din_rdy", hif.din_rdy, 1'b1);
        check1("hard_dout_vld", hif.dout_vld, 1'b0);
        check("hard_lat", VW'(lat), '0);
        check("hard_dout", hif.dout, '0);
        check("hard_core_din", core_din, '0);
        #1 rst = 1'b0;
        r_vld = 1'b0;

        // Backpressure: result held, new input refused until ack
        exp_q.push_back('{dout: E2, lat: 16'd24});
        run_op(D2, 24, 1'b0, n);
        hif.din     = D3;
        hif.din_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check1("bp_din_rdy", hif.din_rdy, 1'b0);
            check1("bp_dout_vld", hif.dout_vld, 1'b1);
            check("bp_core_din", core_din, exp_din(D2));
        end
        exp_q.push_back('{dout: E3, lat: 16'd24});
        hif.dout_ack = 1'b1;
        step();
        hif.dout_ack = 1'b0;
        check1("bp_ack_dout_vld", hif.dout_vld, 1'b0);
        check1("bp_ack_din_rdy", hif.din_rdy, 1'b1);
        step();
        hif.din_vld = 1'b0;
        check("bp_capture", core_din, D3);
        check1("bp_start_trig", trig, 1'b1);
        finish_op(1'b0, n);
        check("bp_cycles", VW'(n), VW'(25));
        ack();

        // Timeout: core never finishes
        run_op(D4, 0, 1'b0, n);
        check("to_cycles", VW'(n), VW'(31));
        check("to_trig_cnt", VW'(trig_cnt), VW'(31));
        check1("to_err", err, 1'b1);
        check1("to_din_rdy", hif.din_rdy, 1'b1);
        check1("to_dout_vld", hif.dout_vld, 1'b0);
        check("to_lat_kept", VW'(lat), VW'(24));
        check("to_dout_kept", hif.dout, E3);

        // Soft clear mid-RUN (err still set from timeout)
        hif.din     = D1;
        hif.din_vld = 1'b1;
        step();
        hif.din_vld = 1'b0;
        r_vld       = 1'b1;
        repeat (5) step();
        check("soft_pre_core_din", core_din, exp_din(D1));
        rst_vld = 1'b1;
        step();
        rst_vld = 1'b0;
        check1("soft_trig", trig, 1'b0);
        check1("soft_err", err, 1'b0);
        check1("soft_din_rdy", hif.din_rdy, 1'b1);
        check1("soft_dout_vld", hif.dout_vld, 1'b0);
        check("soft_lat", VW'(lat), '0);
        check("soft_dout", hif.dout, '0);
        check("soft_core_din", core_din, '0);
        step();
        r_vld = 1'b0;

        // Soft clear beats simultaneous din_vld
        hif.din     = D2;
        hif.din_vld = 1'b1;
        rst_vld     = 1'b1;
        step();
        rst_vld     = 1'b0;
        hif.din_vld = 1'b0;
        check1("simul_trig", trig, 1'b0);
        check1("simul_din_rdy", hif.din_rdy, 1'b1);
        check("simul_core_din", core_din, '0);

        step();
        check("sb_drained", VW'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/masked_dut_shell.md
Name: masked_dut_shell

Overview:
- Parametrised, core-agnostic controller for masked DUTs on the SAKURA-X target. Supports NSHARE shares of STATE_W bits each.
- Sits between the BSV host interface and a masked permutation core.
- Captures shared input, starts the core, gates it on randomness availability, captures the shared result, and reports latency/timeout.
- Drives a scope trigger during computation.

Parameters:
- NSHARE, 2, number of Boolean shares
- STATE_W, 1600, bits per share
- RAND_W, 2, fresh random bits consumed per core cycle
- CNT_W, 16, width of cycle/latency counter
- MAX_CYC, 1000, core-enabled cycles allowed before timeout

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- din  in  NSHARE*STATE_W  input shares concatenated, share k at [k*STATE_W +: STATE_W]
- din_vld  in  1  input valid
- din_rdy  out  1  shell can accept din
- r  in  RAND_W  fresh randomness
- r_vld  in  1  r valid this cycle
- rst_vld  in  1  synchronous soft clear
- dout  out  NSHARE*STATE_W  output shares, same packing as din
- dout_vld  out  1  dout holds a result
- dout_ack  in  1  host consumed result
- trig  out  1  scope trigger
- err  out  1  sticky timeout flag
- lat  out  CNT_W  core-enabled cycles of last completed operation
- core_start  out  1  one-cycle start to core
- core_en  out  1  core clock enable
- core_din  out  NSHARE*STATE_W  registered input shares to core
- core_rand  out  RAND_W  randomness to core (= r)
- core_dout  in  NSHARE*STATE_W  core result shares
- core_done  in  1  core result valid, meaningful only when core_en=1

Behaviour:
- Reset (rst=1, async): state IDLE. din register, dout, lat and counter are all 0. dout_vld=0, err=0, trig=0, core_start=0, core_en=0, din_rdy=1 after reset release.
- FSM states: IDLE, START, RUN, DONE.
- IDLE:
  - din_rdy=1.
  - din_vld=1 latches din into the din register (drives core_din), clears the counter, and moves to START.
- START:
  - core_start=core_en=r_vld.
  - Remains in START until r_vld=1; then moves to RUN and counter=1.
- RUN:
  - core_en=r_vld. core_rand=r combinationally.
  - Counter increments on each cycle with core_en=1.
  - core_done=1 with core_en=1: dout<=core_dout, lat<=counter, move to DONE. dout_vld=1 from the next cycle.
  - core_done with core_en=0 is ignored.
  - Counter reaching MAX_CYC without done: err<=1 (sticky), dout unchanged, move to IDLE.
- DONE:
  - dout_vld=1; dout stable.
  - dout_ack=1 moves to IDLE; dout_vld=0 next cycle; dout retains its value.
  - din_rdy=0 in DONE, so a new din is never accepted before ack.
- trig=1 exactly in START and RUN, registered (no glitches).
- rst_vld=1 in any state has highest priority: next cycle is IDLE, registers are zeroed, dout_vld=0, err=0, and in-flight core work is abandoned (core_en=0).
- Simultaneous rst_vld and din_vld: rst_vld wins and din is not captured.
- Counter saturates at 2^CNT_W-1 and never wraps.
- MAX_CYC must be less than 2^CNT_W; check with an elaboration-time assertion.

Optional Feature:
- DUT_SHELL_DIN_CLEAR_EN defined: the din register is zeroised on the cycle after core_start is asserted, so core_din=0 for the rest of the operation. This assumes the core latches its input at start.
- Undefined: din is held in the register until the next capture or clear.

Decomposition:
- Shared package dut_shell_pkg holds:
  - state enum (IDLE, START, RUN, DONE)
  - default NSHARE/STATE_W/RAND_W constants
  - share-slice helper function (share k of a packed vector)
- Natural sub-module: dut_shell_cnt. It is the saturating enable-gated counter with clear, MAX_CYC compare and lat capture.

Test Plan:
- Basic run: NSHARE=2, STATE_W=1600, r_vld=1 constant, stub core asserts done 24 enabled cycles after start returning din^1 per share -> dout_vld rises 1 cycle after done, dout=din^1, lat=24, trig high for 25 cycles.
- Randomness stall: r_vld low on every other cycle during RUN -> core_en mirrors r_vld, lat still 24, trig spans about 48 cycles, core_done during r_vld=0 ignored.
- Timeout: MAX_CYC=30, core never done -> err=1 at enabled cycle 30, state IDLE, din_rdy=1, dout_vld stays 0; next rst_vld clears err.
- Backpressure: dout_ack held low 10 cycles with din_vld=1 -> din_rdy=0, no capture, dout stable; ack -> dout_vld falls next cycle, then din is captured.
- Soft/hard reset mid-RUN: rst_vld at enabled cycle 5 -> IDLE next cycle, all outputs zero. rst asserted asynchronously mid-RUN -> outputs immediately at reset values.
- Share generalisation: NSHARE=3, STATE_W=64, RAND_W=6 -> share packing preserved end-to-end. With DUT_SHELL_DIN_CLEAR_EN, core_din=0 from 2nd RUN cycle.
